avalon_tx_axis_bridge: RTL and testbench

Final TX-path stage between the Avalon-ST header-alignment stage and the AXI4-Stream PCIe TX interface. Accepts the aligned 128-bit Avalon-ST beats, which carry no backpressure, into a first-word-fall-through FIFO. Derives per-byte `tkeep` for the last beat from the TLP header. Presents the stream as AXI4-Stream with `tready` backpressure, and returns an early `tx_st_ready` to the TLP source so the fixed-latency pipeline never overruns the FIFO.

---
 rtl/avalon_tx_axis_bridge_if.sv | 31 +++
 rtl/avalon_tx_axis_bridge.sv | 169 ++++++++++++++++
 tb/tb_avalon_tx_axis_bridge.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_tx_axis_bridge_if.sv
// AXI4-Stream bundle carrying the bridge's TX output stream.
// The master drives payload and sideband; the slave returns tready.
interface avalon_tx_axis_bridge_if #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/avalon_tx_axis_bridge.sv
// Aligned Avalon-ST TX beats into a FWFT FIFO, emitted as AXI4-Stream.
// Last-beat tkeep comes from the TLP header; tx_st_ready throttles early.
module avalon_tx_axis_bridge #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int KEEP_WIDTH     = AXI_DATA_WIDTH / 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int READY_MARGIN   = 4
) (
    input  logic                      axi_clk,
    input  logic                      axi_rst_n,
    input  logic                      tx_st_valid_align,
    input  logic                      tx_st_sop_align,
    input  logic                      tx_st_eop_align,
    input  logic [AXI_DATA_WIDTH-1:0] tx_st_data_align,
    output logic                      tx_st_ready,
    avalon_tx_axis_bridge_if.master   m_axis,
    output logic                      overflow,
    output logic                      proto_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 + KEEP_WIDTH + AXI_DATA_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] RDY_CNT  = CW'(FIFO_DEPTH - READY_MARGIN);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [EW-1:0]         head;
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  err_set;
    logic [2:0]            fmt;
    logic [9:0]            len;
    logic [10:0]           len_dw;
    logic [10:0]           tot_dw;
    logic [1:0]            hdr_dw;
    logic [1:0]            hdr_dw_q;
    logic [1:0]            sel_dw;
    logic [KEEP_WIDTH-1:0] eop_keep;
    logic [KEEP_WIDTH-1:0] beat_keep;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && m_axis.tready;
    assign push  = accept && (!full || pop);

    // Residue of the TLP DW count; 0 encodes a fully used last beat.
    assign fmt    = tx_st_data_align[31:29];
    assign len    = tx_st_data_align[9:0];
    assign len_dw = (len == '0) ? 11'd1024 : {1'b0, len};
    assign tot_dw = (fmt[0] ? 11'd4 : 11'd3) + (fmt[1] ? len_dw : 11'd0);
    assign hdr_dw = tot_dw[1:0];
    assign sel_dw = tx_st_sop_align ? hdr_dw : hdr_dw_q;

    always_comb begin
        eop_keep = '1;
        unique case (sel_dw)
            2'd1: eop_keep = KEEP_WIDTH'(16'h000F);
            2'd2: eop_keep = KEEP_WIDTH'(16'h00FF);
            2'd3: eop_keep = KEEP_WIDTH'(16'h0FFF);
            2'd0: eop_keep = KEEP_WIDTH'(16'hFFFF);
        endcase
    end

    assign beat_keep = tx_st_eop_align ? eop_keep : '1;

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tx_st_valid_align) begin
            unique case (state)
                IDLE: begin
                    if (tx_st_sop_align && !tx_st_eop_align) begin
                        state_nxt = IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (tx_st_eop_align) begin
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // A stray SOP mid-packet restarts the packet; a headless beat is dropped.
    always_comb begin
        accept  = 1'b0;
        err_set = 1'b0;
        if (tx_st_valid_align) begin
            unique case (state)
                IDLE: begin
                    accept  = tx_st_sop_align;
                    err_set = !tx_st_sop_align;
                end
                IN_PKT: begin
                    accept  = 1'b1;
                    err_set = tx_st_sop_align;
                end
            endcase
        end
    end

    always_ff @(posedge axi_clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= {tx_st_sop_align, tx_st_eop_align,
                                    beat_keep, tx_st_data_align};
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hdr_dw_q    <= '0;
            tx_st_ready <= 1'b0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (tx_st_valid_align && tx_st_sop_align) begin
                hdr_dw_q <= hdr_dw;
            end
            tx_st_ready <= (count <= RDY_CNT);
            if (accept && full && !pop) begin
                overflow <= 1'b1;
            end
            if (err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Head is gated so the stream reads all-zero whenever the FIFO is empty.
    assign head = mem[rd_ptr[PW-1:0]];
    assign m_axis.tvalid = !empty;

    always_comb begin
        {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = '0;
        if (!empty) begin
            {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = head;
        end
    end
endmodule

// File: tb/tb_avalon_tx_axis_bridge.sv
// Directed bench for avalon_tx_axis_bridge with a queue-based reference model.
// Literal checks pin header decode, thresholds and flag behaviour.
`timescale 1ns/1ps
module tb_avalon_tx_axis_bridge;
    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         sop   = 1'b0;
    logic         eop   = 1'b0;
    logic [127:0] data  = '0;
    logic         ready;
    logic         ovf;
    logic         perr;
    int           n_checks = 0;
    int           n_fail   = 0;

    avalon_tx_axis_bridge_if #(.DATA_WIDTH(128)) axis ();

    avalon_tx_axis_bridge dut (
        .axi_clk          (clk),
        .axi_rst_n        (rst_n),
        .tx_st_valid_align(valid),
        .tx_st_sop_align  (sop),
        .tx_st_eop_align  (eop),
        .tx_st_data_align (data),
        .tx_st_ready      (ready),
        .m_axis           (axis),
        .overflow         (ovf),
        .proto_err        (perr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [15:0]  keep;
        logic [127:0] data;
    } beat_t;

    beat_t exp_q[$];
    bit    m_in_pkt = 0;
    int    m_ldw    = 4;
    bit    m_ready  = 0;
    bit    m_ovf    = 0;
    bit    m_perr   = 0;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    function automatic int last_dw_of(input logic [127:0] d);
        int hdr_dws;
        int len_dws;
        int tot;
        hdr_dws = d[29] ? 4 : 3;
        len_dws = (d[9:0] == 10'd0) ? 1024 : int'(d[9:0]);
        tot = hdr_dws + (d[30] ? len_dws : 0);
        return (tot % 4 == 0) ? 4 : tot % 4;
    endfunction

    function automatic logic [15:0] keep_for(input int dw);
        return 16'((32'd1 << (4 * dw)) - 32'd1);
    endfunction

    function automatic logic [127:0] hdr(input logic [2:0] f,
                                         input logic [9:0] l,
                                         input logic [95:0] p);
        return {p, f, 19'h0, l};
    endfunction

    // Effect of the coming rising edge, from the inputs held stable now.
    task automatic model_edge();
        bit    do_pop;
        bit    do_push;
        bit    was_full;
        int    cur;
        beat_t b;
        do_push  = 0;
        was_full = (exp_q.size() == 16);
        do_pop   = (exp_q.size() != 0) && (axis.tready === 1'b1);
        m_ready  = (exp_q.size() <= 12);
        if (valid) begin
            cur = last_dw_of(data);
            if (!sop && !m_in_pkt) begin
                m_perr = 1;
            end else begin
                if (sop && m_in_pkt) m_perr = 1;
                b.sop  = sop;
                b.eop  = eop;
                b.data = data;
                b.keep = eop ? keep_for(sop ? cur : m_ldw) : 16'hFFFF;
                if (was_full && !do_pop) m_ovf = 1;
                else do_push = 1;
                if (sop) begin
                    m_ldw    = cur;
                    m_in_pkt = !eop;
                end else if (eop) begin
                    m_in_pkt = 0;
                end
            end
        end
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tvalid", axis.tvalid, 0);
            chk("rst_tdata", axis.tdata, 0);
            chk("rst_tkeep", axis.tkeep, 0);
            chk("rst_tlast", axis.tlast, 0);
            chk("rst_tuser", axis.tuser, 0);
            chk("rst_ready", ready, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_perr", perr, 0);
            exp_q.delete();
            m_in_pkt = 0;
            m_ready  = 0;
            m_ovf    = 0;
            m_perr   = 0;
        end else begin
            chk("tvalid", axis.tvalid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("tdata", axis.tdata, exp_q[0].data);
                chk("tkeep", axis.tkeep, exp_q[0].keep);
                chk("tlast", axis.tlast, exp_q[0].eop);
                chk("tuser", axis.tuser, exp_q[0].sop);
            end
            chk("tx_st_ready", ready, m_ready);
            chk("overflow", ovf, m_ovf);
            chk("proto_err", perr, m_perr);
            model_edge();
        end
    end

    task automatic beat(input logic s, input logic e,
                        input logic [127:0] d);
        valid = 1'b1;
        sop   = s;
        eop   = e;
        data  = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sop   = 1'b0;
        eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] d;
        int n;
        int pops;
        axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_ready_in_reset", ready, 0);
        chk("lit_tvalid_in_reset", axis.tvalid, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_ready_after_rst", ready, 1);

        // 3DW MWr, 5 DW payload: 8 DW over two beats
        axis.tready = 1'b1;
        d = hdr(3'b010, 10'd5, 96'hA1A1);
        beat(1, 0, d);
        chk("mwr_b1_tvalid", axis.tvalid, 1);
        chk("mwr_b1_tuser", axis.tuser, 1);
        chk("mwr_b1_tlast", axis.tlast, 0);
        chk("mwr_b1_tdata", axis.tdata, d);
        d = {4{32'hB2B2_0001}};
        beat(0, 1, d);
        chk("mwr_b2_tlast", axis.tlast, 1);
        chk("mwr_b2_tkeep", axis.tkeep, 16'hFFFF);
        chk("mwr_b2_tuser", axis.tuser, 0);
        chk("mwr_b2_tdata", axis.tdata, d);
        idle(2);
        chk("mwr_drained", axis.tvalid, 0);

        beat(1, 1, hdr(3'b001, 10'd0, 96'hC3));
        chk("mrd4_tkeep", axis.tkeep, 16'hFFFF);
        chk("mrd4_tlast", axis.tlast, 1);
        chk("mrd4_tuser", axis.tuser, 1);
        beat(1, 1, hdr(3'b000, 10'd1, 96'hC4));
        chk("mrd3_tkeep", axis.tkeep, 16'h0FFF);
        beat(1, 0, hdr(3'b010, 10'd6, 96'hC5));
        beat(0, 0, {4{32'h0000_C501}});
        beat(0, 1, {4{32'h0000_C502}});
        chk("len6_tkeep", axis.tkeep, 16'h000F);
        beat(1, 0, hdr(3'b011, 10'd2, 96'hC6));
        beat(0, 1, {4{32'h0000_C601}});
        chk("4dw_len2_tkeep", axis.tkeep, 16'h00FF);
        beat(1, 0, hdr(3'b010, 10'd0, 96'hC7));
        beat(0, 1, {4{32'h0000_C701}});
        chk("len1024_tkeep", axis.tkeep, 16'h0FFF);
        idle(3);

        // Stream while ready is seen high, then two in-flight beats
        axis.tready = 1'b0;
        n = 0;
        while (ready && n < 40) begin
            d = (n == 0) ? hdr(3'b010, 10'd0, 96'(n + 1))
                         : {4{32'(n) + 32'h100}};
            beat(n == 0, 0, d);
            n++;
        end
        chk("bp_beats_at_fall", n, 14);
        beat(0, 0, {4{32'h0000_0EEE}});
        beat(0, 1, {4{32'h0000_0FFF}});
        chk("bp_no_ovf", ovf, 0);
        chk("bp_ready_low", ready, 0);
        chk("bp_head_tuser", axis.tuser, 1);
        idle(3);
        axis.tready = 1'b1;
        idle(20);
        chk("bp_ready_back", ready, 1);
        chk("bp_drained", axis.tvalid, 0);

        // 17 beats ignoring ready with the sink stalled
        axis.tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            beat(i == 0, i == 16, {4{32'(i) + 32'h200}});
        end
        chk("ovf_set", ovf, 1);
        axis.tready = 1'b1;
        pops = 0;
        repeat (20) begin
            if (axis.tvalid) pops++;
            @(posedge clk);
            #1;
        end
        chk("ovf_stored_beats", pops, 16);
        chk("ovf_sticky", ovf, 1);

        chk("perr_clear", perr, 0);
        beat(0, 0, {4{32'hDEAD_0001}});
        chk("perr_drop", axis.tvalid, 0);
        chk("perr_set", perr, 1);
        beat(1, 0, hdr(3'b010, 10'd3, 96'h5));
        d = hdr(3'b000, 10'd0, 96'h6);
        beat(1, 1, d);
        chk("resop_tuser", axis.tuser, 1);
        chk("resop_tlast", axis.tlast, 1);
        chk("resop_tkeep", axis.tkeep, 16'h0FFF);
        chk("resop_tdata", axis.tdata, d);
        idle(2);

        // Asynchronous reset in the middle of a packet
        axis.tready = 1'b0;
        beat(1, 0, hdr(3'b010, 10'd8, 96'h7));
        beat(0, 0, {4{32'h0000_0701}});
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", axis.tvalid, 0);
        chk("arst_tdata", axis.tdata, 0);
        chk("arst_tkeep", axis.tkeep, 0);
        chk("arst_tuser", axis.tuser, 0);
        chk("arst_ready", ready, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_perr", perr, 0);
        idle(2);
        rst_n = 1'b1;
        axis.tready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready_back", ready, 1);
        chk("arst_empty", axis.tvalid, 0);
        beat(0, 1, {4{32'h0000_0702}});
        idle(3);
        chk("arst_no_stale", axis.tvalid, 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
